// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter: request fields going in,
// grant and one-cycle response coming back.
interface dmem_arbiter_if;
  logic        req;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  width;
  logic        we;
  logic        sext;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, lock, addr, wdata, width, we, sext,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, lock, addr, wdata, width, we, sext,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (p0) and the
// loader/debug port (p1): round-robin, bounded locking, range/width checking.
module dmem_arbiter #(
  parameter int unsigned MAX_LOCK   = 8,
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  p0,
  dmem_arbiter_if.slave  p1,
  output logic [31:0]    mem_addr,
  output logic [31:0]    mem_data,
  output logic [1:0]     mem_width,
  output logic           mem_memwrite,
  output logic           mem_sign_extend,
  input  logic [31:0]    mem_result
);

  localparam logic [7:0]  MAX_CNT = 8'(MAX_LOCK);
  localparam logic [32:0] LIMIT   = 33'(ADDR_LIMIT);

  function automatic logic [2:0] access_bytes(input logic [1:0] width);
    case (width)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // 33-bit end address so accesses near 2^32 cannot wrap back into range.
  function automatic logic access_err(input logic [31:0] addr, input logic [1:0] width);
    logic [32:0] end_addr;
    end_addr = {1'b0, addr} + {30'd0, access_bytes(width)};
    return (width == 2'b11) || (end_addr > LIMIT);
  endfunction

  function automatic logic [31:0] load_result(input logic we, input logic err,
                                              input logic [31:0] data);
    return (!we && !err) ? data : 32'd0;
  endfunction

  logic [1:0]  req;
  logic        own_vld, own_vld_n;
  logic        own_id, own_id_n;
  logic [7:0]  lock_cnt, lock_cnt_n;
  logic        rr_ptr, rr_ptr_n;
  logic        own_req, own_expired;
  logic        gnt_vld, gnt_id;
  logic        sel_lock, sel_we, sel_sext, sel_err;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_width;
  logic [1:0]  vld_p1, err_p1;
  logic [1:0][31:0] rdata_p1;

  assign req = {p1.req, p0.req};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_vld  <= 1'b0;
      own_id   <= 1'b0;
      lock_cnt <= 8'd0;
      rr_ptr   <= 1'b0;
    end else begin
      own_vld  <= own_vld_n;
      own_id   <= own_id_n;
      lock_cnt <= lock_cnt_n;
      rr_ptr   <= rr_ptr_n;
    end
  end

  // An expired owner yields to a requesting peer; alone it competes as a plain request.
  always_comb begin
    own_req     = own_vld && req[own_id];
    own_expired = lock_cnt >= MAX_CNT;
    gnt_vld     = 1'b0;
    gnt_id      = 1'b0;
    if (own_req && !own_expired) begin
      gnt_vld = 1'b1;
      gnt_id  = own_id;
    end else if (&req) begin
      gnt_vld = 1'b1;
      gnt_id  = own_req ? ~own_id : rr_ptr;
    end else if (|req) begin
      gnt_vld = 1'b1;
      gnt_id  = req[1];
    end
    if (!rst_n) gnt_vld = 1'b0;
  end

  always_comb begin
    sel_lock  = gnt_id ? p1.lock  : p0.lock;
    sel_addr  = gnt_id ? p1.addr  : p0.addr;
    sel_wdata = gnt_id ? p1.wdata : p0.wdata;
    sel_width = gnt_id ? p1.width : p0.width;
    sel_we    = gnt_id ? p1.we    : p0.we;
    sel_sext  = gnt_id ? p1.sext  : p0.sext;
    sel_err   = access_err(sel_addr, sel_width);
  end

  always_comb begin
    own_vld_n  = own_vld;
    own_id_n   = own_id;
    lock_cnt_n = lock_cnt;
    rr_ptr_n   = rr_ptr;
    if (gnt_vld) begin
      rr_ptr_n = ~gnt_id;
      if (sel_lock) begin
        own_vld_n  = 1'b1;
        own_id_n   = gnt_id;
        lock_cnt_n = (own_vld && (own_id == gnt_id) && !own_expired) ? lock_cnt + 8'd1 : 8'd1;
      end else begin
        own_vld_n  = 1'b0;
        lock_cnt_n = 8'd0;
      end
    end else if (own_vld && !own_req) begin
      own_vld_n  = 1'b0;
      lock_cnt_n = 8'd0;
    end
  end

  always_comb begin
    p0.gnt          = gnt_vld && !gnt_id;
    p1.gnt          = gnt_vld && gnt_id;
    mem_addr        = 32'd0;
    mem_data        = 32'd0;
    mem_width       = 2'b00;
    mem_memwrite    = 1'b0;
    mem_sign_extend = 1'b0;
    if (gnt_vld) begin
      mem_addr        = sel_addr;
      mem_data        = sel_wdata;
      mem_width       = sel_width;
      mem_memwrite    = sel_we && !sel_err;
      mem_sign_extend = sel_sext;
    end
  end

  // Response stage: captured at the acceptance edge, lives exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 2'b00;
      err_p1   <= 2'b00;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= 2'b00;
      err_p1   <= 2'b00;
      rdata_p1 <= '0;
      if (gnt_vld) begin
        vld_p1[gnt_id]   <= 1'b1;
        err_p1[gnt_id]   <= sel_err;
        rdata_p1[gnt_id] <= load_result(sel_we, sel_err, mem_result);
      end
    end
  end

  assign p0.rvalid = vld_p1[0];
  assign p0.err    = err_p1[0];
  assign p0.rdata  = rdata_p1[0];
  assign p1.rvalid = vld_p1[1];
  assign p1.err    = err_p1[1];
  assign p1.rdata  = rdata_p1[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory, behavioural arbitration model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_dmem_arbiter;

  localparam int MAXL  = 8;
  localparam int LIMIT = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr, mem_data, mem_result;
  logic [1:0]  mem_width;
  logic        mem_memwrite, mem_sign_extend;

  dmem_arbiter_if p0i();
  dmem_arbiter_if p1i();

  dmem_arbiter #(.MAX_LOCK(MAXL), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .p0(p0i), .p1(p1i),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_width(mem_width),
    .mem_memwrite(mem_memwrite), .mem_sign_extend(mem_sign_extend),
    .mem_result(mem_result)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory seen by the DUT, plus an independent reference copy for the model.
  logic [7:0] mem [0:4095] = '{16: 8'hEF, 17: 8'hBE, 18: 8'hAD, 19: 8'hDE, 32: 8'h80, default: 8'h00};
  logic [7:0] ref_mem [0:4095] = '{16: 8'hEF, 17: 8'hBE, 18: 8'hAD, 19: 8'hDE, 32: 8'h80, default: 8'h00};

  logic [11:0] ma;
  logic [31:0] raw;
  assign ma  = mem_addr[11:0];
  assign raw = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

  always_comb begin
    case (mem_width)
      2'b00:   mem_result = mem_sign_extend ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
      2'b01:   mem_result = mem_sign_extend ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: mem_result = raw;
    endcase
  end

  always @(posedge clk) begin
    if (mem_memwrite) begin
      mem[ma] <= mem_data[7:0];
      if (mem_width != 2'b00) mem[ma + 12'd1] <= mem_data[15:8];
      if (mem_width[1]) begin
        mem[ma + 12'd2] <= mem_data[23:16];
        mem[ma + 12'd3] <= mem_data[31:24];
      end
    end
  end

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int n, input bit sx);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
    if (sx && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Model state: owner (-1 none), consecutive owner grants, tie-break turn.
  int          m_own, m_cnt, m_turn, cm_w, cm_n, cm_a;
  bit          m_gnt [2];
  bit          exp_v [2];
  bit          exp_e [2];
  logic [31:0] exp_d [2];
  bit          cm_r [2], cm_lk [2], cm_we [2], cm_sx [2], cm_err;
  logic [31:0] cm_ad [2], cm_wd [2];
  logic [1:0]  cm_wi [2];
  longint      cm_end;

  initial begin
    m_own = -1; m_cnt = 0; m_turn = 0;
    m_gnt = '{0, 0}; exp_v = '{0, 0}; exp_e = '{0, 0}; exp_d = '{0, 0};
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt0", 32'(p0i.gnt), 0);       chk("rst_gnt1", 32'(p1i.gnt), 0);
      chk("rst_rvalid0", 32'(p0i.rvalid), 0); chk("rst_rvalid1", 32'(p1i.rvalid), 0);
      chk("rst_rdata0", p0i.rdata, 0);        chk("rst_rdata1", p1i.rdata, 0);
      chk("rst_err0", 32'(p0i.err), 0);       chk("rst_err1", 32'(p1i.err), 0);
      chk("rst_memwrite", 32'(mem_memwrite), 0);
      m_own = -1; m_cnt = 0; m_turn = 0;
      m_gnt = '{0, 0}; exp_v = '{0, 0};
    end else begin
      chk("rvalid0", 32'(p0i.rvalid), 32'(exp_v[0]));
      chk("rvalid1", 32'(p1i.rvalid), 32'(exp_v[1]));
      if (exp_v[0]) begin chk("rdata0", p0i.rdata, exp_d[0]); chk("err0", 32'(p0i.err), 32'(exp_e[0])); end
      if (exp_v[1]) begin chk("rdata1", p1i.rdata, exp_d[1]); chk("err1", 32'(p1i.err), 32'(exp_e[1])); end

      cm_r[0] = p0i.req;  cm_lk[0] = p0i.lock; cm_ad[0] = p0i.addr; cm_wd[0] = p0i.wdata;
      cm_wi[0] = p0i.width; cm_we[0] = p0i.we; cm_sx[0] = p0i.sext;
      cm_r[1] = p1i.req;  cm_lk[1] = p1i.lock; cm_ad[1] = p1i.addr; cm_wd[1] = p1i.wdata;
      cm_wi[1] = p1i.width; cm_we[1] = p1i.we; cm_sx[1] = p1i.sext;

      cm_w = -1;
      if (m_own >= 0 && cm_r[m_own] && m_cnt < MAXL) cm_w = m_own;
      else if (cm_r[0] && cm_r[1]) cm_w = (m_own >= 0 && cm_r[m_own]) ? 1 - m_own : m_turn;
      else if (cm_r[0]) cm_w = 0;
      else if (cm_r[1]) cm_w = 1;

      m_gnt[0] = (cm_w == 0);
      m_gnt[1] = (cm_w == 1);
      chk("gnt0", 32'(p0i.gnt), 32'(m_gnt[0]));
      chk("gnt1", 32'(p1i.gnt), 32'(m_gnt[1]));
      exp_v = '{0, 0};

      if (cm_w < 0) begin
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_memwrite", 32'(mem_memwrite), 0);
        if (m_own >= 0 && !cm_r[m_own]) begin m_own = -1; m_cnt = 0; end
      end else begin
        cm_n   = nbytes(cm_wi[cm_w]);
        cm_end = longint'(cm_ad[cm_w]) + longint'(cm_n);
        cm_err = (cm_wi[cm_w] == 2'b11) || (cm_end > LIMIT);
        chk("mem_addr", mem_addr, cm_ad[cm_w]);
        chk("mem_data", mem_data, cm_wd[cm_w]);
        chk("mem_width", 32'(mem_width), 32'(cm_wi[cm_w]));
        chk("mem_memwrite", 32'(mem_memwrite), 32'(cm_we[cm_w] && !cm_err));
        chk("mem_sext", 32'(mem_sign_extend), 32'(cm_sx[cm_w]));

        exp_v[cm_w] = 1;
        exp_e[cm_w] = cm_err;
        exp_d[cm_w] = 32'd0;
        if (!cm_err) begin
          cm_a = int'(cm_ad[cm_w][11:0]);
          if (cm_we[cm_w])
            for (int i = 0; i < cm_n; i++) ref_mem[cm_a + i] = cm_wd[cm_w][8 * i +: 8];
          else
            exp_d[cm_w] = ref_load(cm_a, cm_n, cm_sx[cm_w]);
        end

        m_turn = 1 - cm_w;
        if (cm_lk[cm_w]) begin
          m_cnt = (m_own == cm_w && m_cnt < MAXL) ? m_cnt + 1 : 1;
          m_own = cm_w;
        end else begin
          m_own = -1; m_cnt = 0;
        end
      end
    end
  end

  task automatic set_req(input int p, input bit lk, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] w, input bit we, input bit sx);
    if (p == 0) begin
      p0i.req = 1; p0i.lock = lk; p0i.addr = a; p0i.wdata = d; p0i.width = w; p0i.we = we; p0i.sext = sx;
    end else begin
      p1i.req = 1; p1i.lock = lk; p1i.addr = a; p1i.wdata = d; p1i.width = w; p1i.we = we; p1i.sext = sx;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) begin
      p0i.req = 0; p0i.lock = 0; p0i.addr = 0; p0i.wdata = 0; p0i.width = 0; p0i.we = 0; p0i.sext = 0;
    end else begin
      p1i.req = 0; p1i.lock = 0; p1i.addr = 0; p1i.wdata = 0; p1i.width = 0; p1i.we = 0; p1i.sext = 0;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; drop(0); drop(1);
    repeat (2) step();
    rst_n = 1;
  endtask

  task automatic rand_txn(input int p, input bit heavy_lock);
    logic [31:0] a;
    logic [1:0]  w;
    int          sel;
    bit          lk;
    sel = $urandom_range(0, 9);
    if (sel < 7)      a = 32'($urandom_range(0, 63));
    else if (sel < 9) a = 32'(LIMIT - $urandom_range(1, 6));
    else              a = $urandom;
    w  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    lk = heavy_lock ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
    set_req(p, lk, a, $urandom, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    drop(0); drop(1);
    repeat (3) step();
    rst_n = 1;

    // Load word 0x10 from preloaded memory: grant now, data next cycle, then quiet.
    set_req(0, 0, 32'h10, 0, 2'b10, 0, 0);
    @(negedge clk); chk("t1_gnt", 32'(p0i.gnt), 1);
    step(); drop(0);
    @(negedge clk); chk("t1_rvalid", 32'(p0i.rvalid), 1); chk("t1_rdata", p0i.rdata, 32'hDEADBEEF);
    step();
    @(negedge clk); chk("t1_rvalid_off", 32'(p0i.rvalid), 0);
    step();

    // Continuous contention without locking alternates, p0 first.
    do_reset();
    set_req(0, 0, 32'h10, 0, 2'b10, 0, 0);
    set_req(1, 0, 32'h20, 0, 2'b00, 0, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_gnt0", 32'(p0i.gnt), 32'(k % 2 == 0));
      chk("t2_gnt1", 32'(p1i.gnt), 32'(k % 2 == 1));
      if (k > 0) begin
        chk("t2_rvalid0", 32'(p0i.rvalid), 32'(k % 2 == 1));
        chk("t2_rvalid1", 32'(p1i.rvalid), 32'(k % 2 == 0));
      end
      step();
    end
    drop(0); drop(1); step();

    // p1 locks, p0 contends: 8 p1 grants, 1 p0, 8 p1, ...
    do_reset();
    set_req(1, 1, 32'h40, 0, 2'b10, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t3_gnt1", 32'(p1i.gnt), 32'(!(k == 8 || k == 17)));
      chk("t3_gnt0", 32'(p0i.gnt), 32'(k == 8 || k == 17));
      step();
      if (k == 0) set_req(0, 0, 32'h44, 0, 2'b10, 0, 0);
    end
    drop(0); drop(1); step();

    // Store half then sign-extended byte loads.
    set_req(0, 0, 32'h3, 32'h1234, 2'b01, 1, 0);
    @(negedge clk); chk("t4_st_gnt", 32'(p0i.gnt), 1);
    step(); set_req(0, 0, 32'h3, 0, 2'b00, 0, 1);
    @(negedge clk); chk("t4_st_ack", 32'(p0i.rvalid), 1); chk("t4_st_rdata", p0i.rdata, 0);
    step(); drop(0); set_req(1, 0, 32'h20, 0, 2'b00, 0, 1);
    @(negedge clk); chk("t4_ld_rdata", p0i.rdata, 32'h0000_0034); chk("t4_p1_gnt", 32'(p1i.gnt), 1);
    step(); drop(1);
    @(negedge clk); chk("t4_p1_rdata", p1i.rdata, 32'hFFFF_FF80);
    step();

    // Out-of-range and illegal-width stores; word ending exactly at the limit is legal.
    set_req(0, 0, 32'hFFE, 32'hCAFE_F00D, 2'b10, 1, 0);
    @(negedge clk); chk("t5_oor_gnt", 32'(p0i.gnt), 1); chk("t5_oor_memwrite", 32'(mem_memwrite), 0);
    step(); set_req(0, 0, 32'h0, 32'h55AA_55AA, 2'b11, 1, 0);
    @(negedge clk);
    chk("t5_oor_err", 32'(p0i.err), 1); chk("t5_oor_rdata", p0i.rdata, 0);
    chk("t5_w11_memwrite", 32'(mem_memwrite), 0);
    step(); set_req(0, 0, 32'hFFC, 0, 2'b10, 0, 0);
    @(negedge clk);
    chk("t5_w11_err", 32'(p0i.err), 1); chk("t5_w11_rdata", p0i.rdata, 0);
    chk("t5_mem_ffe", 32'(mem[12'hFFE]), 0); chk("t5_mem_0", 32'(mem[12'h000]), 0);
    step(); drop(0);
    @(negedge clk); chk("t5_edge_err", 32'(p0i.err), 0); chk("t5_edge_rvalid", 32'(p0i.rvalid), 1);
    step();

    // Reset right after an acceptance swallows the response; p0 wins the first tie afterwards.
    set_req(0, 0, 32'h10, 0, 2'b10, 0, 0);
    @(negedge clk); chk("t6_gnt", 32'(p0i.gnt), 1);
    step(); rst_n = 0; set_req(1, 0, 32'h20, 0, 2'b10, 0, 0);
    @(negedge clk);
    chk("t6_rvalid", 32'(p0i.rvalid), 0); chk("t6_rdata", p0i.rdata, 0);
    chk("t6_gnt_rst0", 32'(p0i.gnt), 0); chk("t6_gnt_rst1", 32'(p1i.gnt), 0);
    step(); rst_n = 1;
    @(negedge clk); chk("t6_tie0", 32'(p0i.gnt), 1); chk("t6_tie1", 32'(p1i.gnt), 0);
    step();

    // Random traffic; requests stay stable until the model says they were granted.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!((p == 0) ? p0i.req : p1i.req) || m_gnt[p]) begin
          if ($urandom_range(0, 4) != 0) rand_txn(p, (p == 1) && (c >= 1500));
          else drop(p);
        end
      end
      step();
    end
    drop(0); drop(1);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
